// File: rtl/scr1_dmem_arb_pkg.sv
// Shared DMEM interface types and arbiter constants for scr1_dmem_arb.
package scr1_dmem_arb_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH        = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH        = 32;
  localparam int unsigned SCR1_DMEM_ARB_OUTST_MAX = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_ARB_FREE = 1'b0,
    SCR1_ARB_LOCK = 1'b1
  } type_scr1_dmem_arb_fsm_e;

endpackage

// File: rtl/scr1_dmem_arb_ord_fifo.sv
// Owner-id ordering FIFO: 1-bit entries, depth DEPTH, pointers wrap modulo DEPTH.
module scr1_dmem_arb_ord_fifo
  import scr1_dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic wdata,
  output logic rdata,
  output logic empty,
  output logic full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_ok) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/scr1_dmem_arb.sv
// Two-master DMEM arbiter with in-order response routing.
// SCR1_DMEM_ARB_RR_EN selects round-robin arbitration; SCR1_SIM_ENV enables assertions.
module scr1_dmem_arb
  import scr1_dmem_arb_pkg::*;
#(
  parameter int unsigned OUTST_NUM = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        m0_req,
  input  type_scr1_mem_cmd_e          m0_cmd,
  input  type_scr1_mem_width_e        m0_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] m0_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] m0_wdata,
  output logic                        m0_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] m0_rdata,
  output type_scr1_mem_resp_e         m0_resp,
  input  logic                        m1_req,
  input  type_scr1_mem_cmd_e          m1_cmd,
  input  type_scr1_mem_width_e        m1_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] m1_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] m1_wdata,
  output logic                        m1_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] m1_rdata,
  output type_scr1_mem_resp_e         m1_resp,
  output logic                        arb2dmem_req,
  output type_scr1_mem_cmd_e          arb2dmem_cmd,
  output type_scr1_mem_width_e        arb2dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] arb2dmem_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] arb2dmem_wdata,
  input  logic                        dmem2arb_req_ack,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem2arb_rdata,
  input  type_scr1_mem_resp_e         dmem2arb_resp,
  output logic                        arb_busy
);

  localparam int unsigned CntW = $clog2(SCR1_DMEM_ARB_OUTST_MAX + 1);

  type_scr1_dmem_arb_fsm_e state_q, state_d;
  logic                    owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    arb_en_q;
  logic                    full, gnt_vld, gnt_id, accepted, resp_rdy, pop, head;
  logic                    fifo_empty, fifo_full;
`ifdef SCR1_DMEM_ARB_RR_EN
  logic                    rr_q, rr_d;
`endif

  // arb_en_q keeps every output at its reset value for one cycle after release
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == SCR1_ARB_LOCK) begin
      gnt_id  = owner_q;
      gnt_vld = owner_q ? m1_req : m0_req;
    end else begin
`ifdef SCR1_DMEM_ARB_RR_EN
      gnt_id = (m0_req & m1_req) ? rr_q : ~m0_req;
`else
      gnt_id = ~m0_req;
`endif
      gnt_vld = m0_req | m1_req;
    end
  end

  assign full         = (cnt_q == CntW'(OUTST_NUM));
  assign arb2dmem_req = arb_en_q & gnt_vld & ~full;
  assign accepted     = arb2dmem_req & dmem2arb_req_ack;
  assign m0_req_ack   = accepted & ~gnt_id;
  assign m1_req_ack   = accepted & gnt_id;

  assign arb2dmem_cmd   = gnt_id ? m1_cmd   : m0_cmd;
  assign arb2dmem_width = gnt_id ? m1_width : m0_width;
  assign arb2dmem_addr  = gnt_id ? m1_addr  : m0_addr;
  assign arb2dmem_wdata = gnt_id ? m1_wdata : m0_wdata;

  assign resp_rdy = (dmem2arb_resp == SCR1_MEM_RESP_RDY_OK)
                  | (dmem2arb_resp == SCR1_MEM_RESP_RDY_ER);
  // Responses arriving with nothing outstanding are dropped
  assign pop      = arb_en_q & resp_rdy & ~fifo_empty;

  assign m0_resp  = (pop & ~head) ? dmem2arb_resp : SCR1_MEM_RESP_NOTRDY;
  assign m1_resp  = (pop & head)  ? dmem2arb_resp : SCR1_MEM_RESP_NOTRDY;
  assign m0_rdata = (pop & ~head) ? dmem2arb_rdata : '0;
  assign m1_rdata = (pop & head)  ? dmem2arb_rdata : '0;
  assign arb_busy = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      SCR1_ARB_FREE: begin
        if (arb_en_q & gnt_vld & ~accepted) begin
          state_d = SCR1_ARB_LOCK;
          owner_d = gnt_id;
        end
      end
      SCR1_ARB_LOCK: if (accepted) state_d = SCR1_ARB_FREE;
      default:       state_d = SCR1_ARB_FREE;
    endcase
    cnt_d = cnt_q + CntW'(accepted) - CntW'(pop);
  end

`ifdef SCR1_DMEM_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (accepted & m0_req & m1_req) rr_d = ~gnt_id;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCR1_ARB_FREE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      arb_en_q <= 1'b0;
`ifdef SCR1_DMEM_ARB_RR_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      arb_en_q <= 1'b1;
`ifdef SCR1_DMEM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  scr1_dmem_arb_ord_fifo #(
    .DEPTH (OUTST_NUM)
  ) i_ord_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accepted & ~fifo_full),
    .pop   (pop),
    .wdata (gnt_id),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef SCR1_SIM_ENV
  a_ctrl_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({m0_req, m1_req, dmem2arb_req_ack, dmem2arb_resp}));
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({gnt_vld & gnt_id, gnt_vld & ~gnt_id}));
  a_no_resp_empty: assert property (@(posedge clk) disable iff (!rst_n)
    resp_rdy |-> !fifo_empty);
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CntW'(OUTST_NUM));
`endif

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Directed and randomized bench for scr1_dmem_arb against a queue-based reference model.
module tb_scr1_dmem_arb;
  import scr1_dmem_arb_pkg::*;

  localparam int unsigned OUTST = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 m0_req, m1_req, m0_req_ack, m1_req_ack;
  type_scr1_mem_cmd_e   m0_cmd, m1_cmd, arb2dmem_cmd;
  type_scr1_mem_width_e m0_width, m1_width, arb2dmem_width;
  logic [31:0]          m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  type_scr1_mem_resp_e  m0_resp, m1_resp, dmem2arb_resp;
  logic                 arb2dmem_req, dmem2arb_req_ack, arb_busy;
  logic [31:0]          arb2dmem_addr, arb2dmem_wdata, dmem2arb_rdata;

  always #5 clk = ~clk;

  scr1_dmem_arb #(.OUTST_NUM(OUTST)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_req           (m0_req),
    .m0_cmd           (m0_cmd),
    .m0_width         (m0_width),
    .m0_addr          (m0_addr),
    .m0_wdata         (m0_wdata),
    .m0_req_ack       (m0_req_ack),
    .m0_rdata         (m0_rdata),
    .m0_resp          (m0_resp),
    .m1_req           (m1_req),
    .m1_cmd           (m1_cmd),
    .m1_width         (m1_width),
    .m1_addr          (m1_addr),
    .m1_wdata         (m1_wdata),
    .m1_req_ack       (m1_req_ack),
    .m1_rdata         (m1_rdata),
    .m1_resp          (m1_resp),
    .arb2dmem_req     (arb2dmem_req),
    .arb2dmem_cmd     (arb2dmem_cmd),
    .arb2dmem_width   (arb2dmem_width),
    .arb2dmem_addr    (arb2dmem_addr),
    .arb2dmem_wdata   (arb2dmem_wdata),
    .dmem2arb_req_ack (dmem2arb_req_ack),
    .dmem2arb_rdata   (dmem2arb_rdata),
    .dmem2arb_resp    (dmem2arb_resp),
    .arb_busy         (arb_busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of issuing masters, pending-grant owner, RR favourite
  int q[$];
  int pend = -1;
  int rr   = 0;
  bit en   = 1'b0;
  int g;
  bit gv, exp_req, acc, pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_cmd = SCR1_MEM_CMD_RD; m0_width = SCR1_MEM_WIDTH_WORD;
    m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_cmd = SCR1_MEM_CMD_RD; m1_width = SCR1_MEM_WIDTH_WORD;
    m1_addr = '0; m1_wdata = '0;
    dmem2arb_req_ack = 1'b0; dmem2arb_resp = SCR1_MEM_RESP_NOTRDY; dmem2arb_rdata = '0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req"}, arb2dmem_req, 1'b0);
    chk({tag, "_ack0"}, m0_req_ack, 1'b0);
    chk({tag, "_ack1"}, m1_req_ack, 1'b0);
    chk({tag, "_resp0"}, m0_resp, SCR1_MEM_RESP_NOTRDY);
    chk({tag, "_resp1"}, m1_resp, SCR1_MEM_RESP_NOTRDY);
    chk({tag, "_rdata0"}, m0_rdata, 32'h0);
    chk({tag, "_rdata1"}, m1_rdata, 32'h0);
    chk({tag, "_busy"}, arb_busy, 1'b0);
  endtask

  // Assert reset now, check outputs, release after the next rising edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    dmem2arb_resp = SCR1_MEM_RESP_NOTRDY;
    q.delete(); pend = -1; rr = 0; en = 1'b0;
    #1 chk_rst(tag);
    @(posedge clk); #1;
    chk_rst(tag);
    rst_n = 1'b1;
  endtask

  task automatic drive_check();
    bit full;
    type_scr1_mem_resp_e r0, r1;
    logic [31:0] d0, d1;
    full = (q.size() == OUTST);
    gv = 1'b0; g = 0;
    if (pend >= 0) begin g = pend; gv = 1'b1; end
`ifdef SCR1_DMEM_ARB_RR_EN
    else if (m0_req && m1_req) begin g = rr; gv = 1'b1; end
`endif
    else if (m0_req) begin g = 0; gv = 1'b1; end
    else if (m1_req) begin g = 1; gv = 1'b1; end
    exp_req = en && gv && !full;
    acc = exp_req && dmem2arb_req_ack;
    pop = en && (q.size() > 0) && (dmem2arb_resp == SCR1_MEM_RESP_RDY_OK ||
                                   dmem2arb_resp == SCR1_MEM_RESP_RDY_ER);
    r0 = SCR1_MEM_RESP_NOTRDY; r1 = SCR1_MEM_RESP_NOTRDY; d0 = '0; d1 = '0;
    if (pop && q[0] == 0) begin r0 = dmem2arb_resp; d0 = dmem2arb_rdata; end
    if (pop && q[0] == 1) begin r1 = dmem2arb_resp; d1 = dmem2arb_rdata; end
    @(negedge clk);
    chk("req", arb2dmem_req, exp_req);
    if (exp_req) begin
      chk("addr", arb2dmem_addr, (g == 1) ? m1_addr : m0_addr);
      chk("wdata", arb2dmem_wdata, (g == 1) ? m1_wdata : m0_wdata);
      chk("cmd", arb2dmem_cmd, (g == 1) ? m1_cmd : m0_cmd);
      chk("width", arb2dmem_width, (g == 1) ? m1_width : m0_width);
    end
    chk("ack0", m0_req_ack, acc && g == 0);
    chk("ack1", m1_req_ack, acc && g == 1);
    chk("resp0", m0_resp, r0);
    chk("resp1", m1_resp, r1);
    chk("rdata0", m0_rdata, d0);
    chk("rdata1", m1_rdata, d1);
    chk("busy", arb_busy, q.size() != 0);
  endtask

  task automatic advance();
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(g);
    pend = (en && gv && !acc) ? g : -1;
    if (acc && m0_req && m1_req) rr = 1 - g;
    en = 1'b1;
    #1;
  endtask

  initial begin
    bit exp0;
    idle();
    // Requests already up while in reset must not issue in the release cycle
    m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200;
    dmem2arb_req_ack = 1'b1;
    do_reset("rst");
    drive_check(); chk("rel_req", arb2dmem_req, 1'b0); advance();

    // Fixed priority: m0 first, then m1; responses routed in order
    drive_check(); chk("fp_ack0", m0_req_ack, 1'b1); chk("fp_addr0", arb2dmem_addr, 32'h100);
    advance();
    m0_req = 1'b0;
    drive_check(); chk("fp_ack1", m1_req_ack, 1'b1); chk("fp_addr1", arb2dmem_addr, 32'h200);
    advance();
    m1_req = 1'b0; dmem2arb_req_ack = 1'b0;
    dmem2arb_resp = SCR1_MEM_RESP_RDY_OK; dmem2arb_rdata = 32'hAAAA_5555;
    drive_check(); chk("fp_rd0", m0_rdata, 32'hAAAA_5555); chk("fp_rsp0", m0_resp, SCR1_MEM_RESP_RDY_OK);
    advance();
    dmem2arb_rdata = 32'h1234_5678;
    drive_check(); chk("fp_rd1", m1_rdata, 32'h1234_5678); chk("fp_rsp1", m1_resp, SCR1_MEM_RESP_RDY_OK);
    advance();
    dmem2arb_resp = SCR1_MEM_RESP_NOTRDY; dmem2arb_rdata = '0;

    // Lock: m1 keeps the port through three unacked cycles despite m0
    m1_req = 1'b1; m1_addr = 32'h300; m1_cmd = SCR1_MEM_CMD_WR; m1_wdata = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin m0_req = 1'b1; m0_addr = 32'h400; end
      dmem2arb_req_ack = (i >= 3);
      drive_check();
      chk("lock_addr", arb2dmem_addr, (i == 4) ? 32'h400 : 32'h300);
      advance();
      if (i == 3) m1_req = 1'b0;
    end
    m0_req = 1'b0; dmem2arb_req_ack = 1'b0;

    // Full: two outstanding, third request blocked until the cycle after a response
    m0_req = 1'b1; m0_addr = 32'h500; dmem2arb_req_ack = 1'b1; dmem2arb_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      dmem2arb_resp = (i == 2) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      drive_check();
      chk("full_req", arb2dmem_req, i == 3);
      chk("full_ack", m0_req_ack, i == 3);
      if (i == 3) chk("full_busy", arb_busy, 1'b1);
      advance();
    end
    m0_req = 1'b0; dmem2arb_req_ack = 1'b0;

    // Simultaneous push and pop
    dmem2arb_resp = SCR1_MEM_RESP_RDY_OK; dmem2arb_rdata = 32'h1111_1111;
    drive_check(); advance();
    m1_req = 1'b1; m1_addr = 32'h600; m1_cmd = SCR1_MEM_CMD_RD; dmem2arb_req_ack = 1'b1;
    dmem2arb_rdata = 32'h2222_2222;
    drive_check(); chk("pp_rsp0", m0_resp, SCR1_MEM_RESP_RDY_OK); chk("pp_ack1", m1_req_ack, 1'b1);
    advance();
    m1_req = 1'b0; dmem2arb_req_ack = 1'b0; dmem2arb_rdata = 32'h3333_3333;
    drive_check(); chk("pp_busy", arb_busy, 1'b1); chk("pp_rsp1", m1_resp, SCR1_MEM_RESP_RDY_OK);
    chk("pp_rd1", m1_rdata, 32'h3333_3333);
    advance();
    dmem2arb_resp = SCR1_MEM_RESP_NOTRDY;

    // Error response routed to m1
    m1_req = 1'b1; m1_addr = 32'h700; dmem2arb_req_ack = 1'b1;
    drive_check(); advance();
    m1_req = 1'b0; dmem2arb_req_ack = 1'b0;
    dmem2arb_resp = SCR1_MEM_RESP_RDY_ER; dmem2arb_rdata = 32'hDEAD_BEEF;
    drive_check(); chk("er_rsp1", m1_resp, SCR1_MEM_RESP_RDY_ER);
    chk("er_rsp0", m0_resp, SCR1_MEM_RESP_NOTRDY);
    advance();
    dmem2arb_resp = SCR1_MEM_RESP_NOTRDY;
    drive_check(); chk("er_busy", arb_busy, 1'b0); advance();

    // Reset with two transactions outstanding
    m0_req = 1'b1; m0_addr = 32'h800; dmem2arb_req_ack = 1'b1;
    drive_check(); advance();
    drive_check(); chk("pre_rst_busy", arb_busy, 1'b1); advance();
    #2;
    m1_req = 1'b1; m1_addr = 32'h900;
    do_reset("rst_mid");
    drive_check(); chk("rel2_req", arb2dmem_req, 1'b0); chk("rel2_busy", arb_busy, 1'b0);
    advance();

    // Both masters requesting with constant ack
    for (int i = 0; i < 4; i++) begin
      dmem2arb_resp = (i > 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      dmem2arb_rdata = 32'h5000_0000 + 32'(i);
`ifdef SCR1_DMEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      drive_check();
      chk("alt_ack0", m0_req_ack, exp0);
      chk("alt_ack1", m1_req_ack, !exp0);
      advance();
    end
    m0_req = 1'b0; m1_req = 1'b0; dmem2arb_req_ack = 1'b0;
    drive_check(); advance();
    dmem2arb_resp = SCR1_MEM_RESP_NOTRDY;

    // Randomized traffic; masters hold fields until acknowledged
    for (int c = 0; c < 400; c++) begin
      if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
        m0_cmd = type_scr1_mem_cmd_e'($urandom_range(0, 1));
        m0_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      end
      if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
        m1_cmd = type_scr1_mem_cmd_e'($urandom_range(0, 1));
        m1_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      end
      dmem2arb_req_ack = 1'($urandom_range(0, 1));
      if (q.size() > 0 && $urandom_range(0, 2) != 0)
        dmem2arb_resp = ($urandom_range(0, 3) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      else
        dmem2arb_resp = SCR1_MEM_RESP_NOTRDY;
      dmem2arb_rdata = $urandom;
      drive_check();
      advance();
      if (acc && g == 0) m0_req = 1'b0;
      if (acc && g == 1) m1_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scr1_dmem_arb.md
Name: scr1_dmem_arb

Overview:
- Two-requester arbiter for the single DMEM port.
- Shares the port between the LSU (port 0) and a secondary master (port 1): the debug abstract-access / system-bus master.
- Issues up to OUTST_NUM in-order outstanding transactions and routes each DMEM response back to the master that issued it.
- Sits between scr1_pipe_lsu and the core-level DMEM router.

Parameters:
- OUTST_NUM, 2, max in-flight DMEM transactions (1..4); sets the depth of the response-ordering FIFO.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  LSU request
- m0_cmd  in  type_scr1_mem_cmd_e  LSU command
- m0_width  in  type_scr1_mem_width_e  LSU width
- m0_addr  in  SCR1_DMEM_AWIDTH  LSU address
- m0_wdata  in  SCR1_DMEM_DWIDTH  LSU write data
- m0_req_ack  out  1  LSU request accepted
- m0_rdata  out  SCR1_DMEM_DWIDTH  LSU read data
- m0_resp  out  type_scr1_mem_resp_e  LSU response
- m1_req, m1_cmd, m1_width, m1_addr, m1_wdata, m1_req_ack, m1_rdata, m1_resp: same directions, widths and meanings for master 1
- arb2dmem_req  out  1  DMEM request
- arb2dmem_cmd  out  type_scr1_mem_cmd_e  DMEM command
- arb2dmem_width  out  type_scr1_mem_width_e  DMEM width
- arb2dmem_addr  out  SCR1_DMEM_AWIDTH  DMEM address
- arb2dmem_wdata  out  SCR1_DMEM_DWIDTH  DMEM write data
- dmem2arb_req_ack  in  1  DMEM accepted request
- dmem2arb_rdata  in  SCR1_DMEM_DWIDTH  DMEM read data
- dmem2arb_resp  in  type_scr1_mem_resp_e  DMEM response
- arb_busy  out  1  at least one transaction outstanding

Behaviour:
- Reset: both outputs below hold their values while rst_n is low and in the first cycle after release.
  - Register state: outstanding counter 0, ordering FIFO empty, lock state ARB_FREE, RR pointer 0.
  - Outputs: arb2dmem_req 0; m0/m1_req_ack 0; m0/m1_resp SCR1_MEM_RESP_NOTRDY; arb_busy 0.
  - rdata outputs: '0 when the port is not the response owner.
- Lock FSM, ARB_FREE / ARB_LOCK:
  - ARB_FREE: the granted master is chosen combinationally in the same cycle. Default policy is fixed priority, m0 over m1.
  - arb2dmem_* carry the granted master's fields with zero added latency.
  - Request with no dmem2arb_req_ack: go to ARB_LOCK and record the owner. The grant stays with that master until its ack, even if the other master raises req. Masters must hold req and fields stable until ack.
  - ARB_LOCK, ack seen: return to ARB_FREE. The lock must never switch owner.
- Ack routing: m<i>_req_ack = dmem2arb_req_ack & grant_i & ~full. The non-granted master's ack is always 0.
- Full condition: counter == OUTST_NUM.
  - arb2dmem_req is forced to 0 and no acks are passed.
  - The lock state is retained.
- Ordering FIFO:
  - On an accepted request (arb2dmem_req & dmem2arb_req_ack), push the owner id and increment the counter.
  - On dmem2arb_resp == RDY_OK or RDY_ER, pop the head and decrement the counter.
  - The response and rdata are routed to the head owner; the other port sees NOTRDY and rdata '0.
  - Simultaneous push and pop: the counter is unchanged and the FIFO read/write pointers both advance.
  - Pointers wrap modulo OUTST_NUM.
- Full with a response in the same cycle: the new request stays blocked that cycle. The full check uses the registered counter, so there is no comb path from resp to req.
- Response while FIFO empty: dropped, with no routing and no counter underflow. Flagged by an SVA under SCR1_SIM_ENV.
- arb_busy = (counter != 0).
- Reset mid-transaction: all state is cleared. The DMEM side is reset together with the arbiter, so no late responses arrive.
- SVA under SCR1_SIM_ENV:
  - X-check on control inputs.
  - Grant is one-hot0.
  - No response while empty.
  - Counter never exceeds OUTST_NUM.

Optional Feature:
- SCR1_DMEM_ARB_RR_EN defined: ARB_FREE arbitration is round-robin.
  - A 1-bit pointer favours the master not served by the last accepted request.
  - The pointer flips on each accepted request when both masters were requesting.
- Undefined: fixed priority, m0 over m1; the pointer logic is absent.

Decomposition:
- scr1_memif.svh (existing) supplies type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e.
- Add to it:
  - type_scr1_dmem_arb_fsm_e {SCR1_ARB_FREE, SCR1_ARB_LOCK}
  - localparam SCR1_DMEM_ARB_OUTST_MAX = 4
- One sub-module, scr1_dmem_arb_ord_fifo: parameterised depth, 1-bit data, push/pop/empty/full, async reset. It holds the owner-id queue.

Test Plan:
- Fixed priority: m0 and m1 both request at addr 0x100 / 0x200 with immediate ack. m0 is acked in cycle 0 and m1 in cycle 1. Responses with rdata 0xAAAA_5555 then 0x1234_5678 appear on m0_rdata then m1_rdata, each with RDY_OK.
- Lock: m1 requests and ack is held low 3 cycles; m0 raises req in cycle 1. arb2dmem_addr stays m1's value until the ack in cycle 3, then switches to m0 in cycle 4.
- Full: with OUTST_NUM=2, two acked requests and no response. A third m0 request sees arb2dmem_req=0 and m0_req_ack=0 until the first RDY_OK. The request issues the next cycle and arb_busy stays 1.
- Simultaneous push/pop: counter=1, a response and a new accepted request in the same cycle. The counter stays 1 and the next response is routed to the new owner.
- Error response: m1 read, DMEM returns RDY_ER. m1_resp=RDY_ER, m0_resp=NOTRDY, and the counter returns to 0.
- RR (with SCR1_DMEM_ARB_RR_EN): both masters request continuously with constant ack. Grants alternate m0, m1, m0, m1 over 4 cycles.
- Reset asserted with 2 transactions outstanding: all outputs take reset values immediately and arb_busy=0 after release.
